output_sram_bank: RTL and testbench

OUTPUT_SRAM_BANK -- requirements
Module: output_sram_bank

---
 rtl/output_sram_bank_pkg.sv | 39 +++
 rtl/output_sram_array.sv | 28 ++
 rtl/output_sram_bank.sv | 192 +++++++++++++++++++
 tb/tb_output_sram_bank.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_sram_bank_pkg.sv
// Shared types and sizing for the output feature-vector SRAM banks.
package output_sram_bank_pkg;

  localparam int unsigned NUM_BANKS_FV = 4;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned NODE_ID_W    = 8;
  localparam int unsigned PE_TAG_W     = 4;
  localparam int unsigned BANK_BITS    = $clog2(NUM_BANKS_FV);

  typedef struct packed {
    logic                 valid;
    logic [PE_TAG_W-1:0]  PE_tag;
    logic                 rd_wr;
    logic [NODE_ID_W-1:0] Node_id;
    logic [DATA_W-1:0]    data;
    logic                 wr_sos;
    logic                 wr_eos;
  } Req2Output_SRAM_Bank;

  typedef struct packed {
    logic                 valid;
    logic [PE_TAG_W-1:0]  PE_tag;
    logic [NODE_ID_W-1:0] Node_id;
    logic [DATA_W-1:0]    data;
    logic                 sos;
    logic                 eos;
  } Output_Sram2PE;

  typedef struct packed {
    logic eos;
  } Output_Sram2Arbiter;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } bank_state_e;

endpackage

// File: rtl/output_sram_array.sv
// Single-port synchronous word memory: one read or write per cycle, 1-cycle read latency.
module output_sram_array
  import output_sram_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read port register is cleared so the bank's read data is 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset)            rdata <= '0;
    else if (en && !we)   rdata <= mem[addr];
  end

endmodule

// File: rtl/output_sram_bank.sv
// One bank of the output feature-vector store: burst reads back to PEs, burst writes from the arbiter.
module output_sram_bank
  import output_sram_bank_pkg::*;
#(
  parameter int unsigned BANK_ID        = 0,
  parameter int unsigned FV_BEATS       = 4,
  parameter int unsigned NODES_PER_BANK = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  Req2Output_SRAM_Bank req_in,
  output Output_Sram2PE       rd_out,
  output Output_Sram2Arbiter  arb_out,
  output logic                err
);

  localparam int unsigned DEPTH  = FV_BEATS * NODES_PER_BANK;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BEAT_W = $clog2(FV_BEATS + 1);

  bank_state_e          state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [PE_TAG_W-1:0]  tag_q, tag_d;
  logic [NODE_ID_W-1:0] node_q, node_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_sos_q, rd_sos_d;
  logic                 rd_eos_q, rd_eos_d;
  logic                 err_q, err_d;

  logic                 sram_en_c;
  logic                 sram_we_c;
  logic [ADDR_W-1:0]    sram_addr_c;
  logic [DATA_W-1:0]    sram_wdata_c;
  logic [DATA_W-1:0]    sram_rdata;
  logic                 bank_hit_c;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [NODE_ID_W-1:0] node,
                                                  input logic [BEAT_W-1:0]    beat);
    return ADDR_W'(node[NODE_ID_W-1:BANK_BITS]) * ADDR_W'(FV_BEATS) + ADDR_W'(beat);
  endfunction

  assign bank_hit_c = (req_in.Node_id[BANK_BITS-1:0] == BANK_BITS'(BANK_ID));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      tag_q      <= '0;
      node_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_sos_q   <= 1'b0;
      rd_eos_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      tag_q      <= tag_d;
      node_q     <= node_d;
      rd_valid_q <= rd_valid_d;
      rd_sos_q   <= rd_sos_d;
      rd_eos_q   <= rd_eos_d;
      err_q      <= err_d;
    end
  end

  // Next state, SRAM command for this cycle, and read-return flags for the next.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    tag_d        = tag_q;
    node_d       = node_q;
    err_d        = err_q;
    rd_valid_d   = 1'b0;
    rd_sos_d     = 1'b0;
    rd_eos_d     = 1'b0;
    sram_en_c    = 1'b0;
    sram_we_c    = 1'b0;
    sram_addr_c  = '0;
    sram_wdata_c = req_in.data;

    unique case (state_q)
      ST_IDLE: begin
        if (req_in.valid) begin
          if (!bank_hit_c) begin
            err_d = 1'b1;
          end else if (!req_in.rd_wr) begin
            tag_d       = req_in.PE_tag;
            node_d      = req_in.Node_id;
            sram_en_c   = 1'b1;
            sram_addr_c = word_addr(req_in.Node_id, '0);
            rd_valid_d  = 1'b1;
            rd_sos_d    = 1'b1;
            if (FV_BEATS == 1) begin
              rd_eos_d = 1'b1;
            end else begin
              state_d = ST_RD;
              beat_d  = BEAT_W'(1);
            end
          end else if (req_in.wr_sos) begin
            node_d      = req_in.Node_id;
            sram_en_c   = 1'b1;
            sram_we_c   = 1'b1;
            sram_addr_c = word_addr(req_in.Node_id, '0);
            if (!req_in.wr_eos) begin
              state_d = ST_WR;
              beat_d  = BEAT_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RD: begin
        if (req_in.valid) err_d = 1'b1;
        sram_en_c   = 1'b1;
        sram_addr_c = word_addr(node_q, beat_q);
        rd_valid_d  = 1'b1;
        if (beat_q == BEAT_W'(FV_BEATS - 1)) begin
          rd_eos_d = 1'b1;
          state_d  = ST_IDLE;
          beat_d   = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end

      ST_WR: begin
        if (req_in.valid) begin
          if (!bank_hit_c || !req_in.rd_wr) begin
            err_d = 1'b1;
          end else begin
            if (req_in.wr_sos) begin
              // A fresh start-of-burst restarts the vector from beat 0.
              err_d       = 1'b1;
              node_d      = req_in.Node_id;
              sram_en_c   = 1'b1;
              sram_we_c   = 1'b1;
              sram_addr_c = word_addr(req_in.Node_id, '0);
              beat_d      = BEAT_W'(1);
            end else begin
              if (beat_q < BEAT_W'(FV_BEATS)) begin
                sram_en_c   = 1'b1;
                sram_we_c   = 1'b1;
                sram_addr_c = word_addr(node_q, beat_q);
                beat_d      = beat_q + BEAT_W'(1);
              end else begin
                err_d = 1'b1;
              end
            end
            if (req_in.wr_eos) begin
              state_d = ST_IDLE;
              beat_d  = '0;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  output_sram_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (sram_en_c),
    .we    (sram_we_c),
    .addr  (sram_addr_c),
    .wdata (sram_wdata_c),
    .rdata (sram_rdata)
  );

  always_comb begin
    rd_out         = '0;
    rd_out.valid   = rd_valid_q;
    rd_out.PE_tag  = tag_q;
    rd_out.Node_id = node_q;
    rd_out.data    = sram_rdata;
    rd_out.sos     = rd_sos_q;
    rd_out.eos     = rd_eos_q;
    arb_out        = '0;
    arb_out.eos    = rd_eos_q;
  end

  assign err = err_q;

endmodule

// File: tb/tb_output_sram_bank.sv
// Scoreboard bench for output_sram_bank: reference array model, expected-read queue, negedge monitor.
module tb_output_sram_bank;
  import output_sram_bank_pkg::*;

  localparam int unsigned BANK_ID = 1;
  localparam int unsigned FV      = 4;
  localparam int unsigned NODES   = 64;

  logic                clk = 1'b0;
  logic                reset;
  Req2Output_SRAM_Bank req;
  Output_Sram2PE       rd_out;
  Output_Sram2Arbiter  arb_out;
  logic                err;

  always #5 clk = ~clk;

  output_sram_bank #(
    .BANK_ID        (BANK_ID),
    .FV_BEATS       (FV),
    .NODES_PER_BANK (NODES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_in  (req),
    .rd_out  (rd_out),
    .arb_out (arb_out),
    .err     (err)
  );

  typedef struct {
    logic [PE_TAG_W-1:0]  tag;
    logic [NODE_ID_W-1:0] node;
    logic [DATA_W-1:0]    data;
    logic                 sos;
    logic                 eos;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] model [NODES][FV];
  int                checks = 0;
  int                errors = 0;
  bit                exp_err = 1'b0;
  bit                mon_en = 1'b0;

  function automatic logic [NODE_ID_W-1:0] node_of(input int idx);
    return NODE_ID_W'(idx * NUM_BANKS_FV + BANK_ID);
  endfunction

  function automatic int idx_of(input logic [NODE_ID_W-1:0] node);
    return int'(node) / NUM_BANKS_FV;
  endfunction

  // Every driven read-return word must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_out.valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got word %h node %0d tag %0d, required no output",
                   rd_out.data, rd_out.Node_id, rd_out.PE_tag);
        end else begin
          mon_e = exp_q.pop_front();
          if (rd_out.data !== mon_e.data || rd_out.PE_tag !== mon_e.tag ||
              rd_out.Node_id !== mon_e.node || rd_out.sos !== mon_e.sos ||
              rd_out.eos !== mon_e.eos) begin
            errors++;
            $display("FAIL rd_word: got data %h tag %0d node %0d sos %b eos %b, required data %h tag %0d node %0d sos %b eos %b",
                     rd_out.data, rd_out.PE_tag, rd_out.Node_id, rd_out.sos, rd_out.eos,
                     mon_e.data, mon_e.tag, mon_e.node, mon_e.sos, mon_e.eos);
          end
          checks++;
          if (arb_out.eos !== mon_e.eos) begin
            errors++;
            $display("FAIL arb_eos: got %b, required %b", arb_out.eos, mon_e.eos);
          end
        end
      end else if (arb_out.eos !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL arb_eos_idle: got %b, required 0 without a read word", arb_out.eos);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic rd_wr, input logic [NODE_ID_W-1:0] node,
                      input logic [PE_TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                      input logic sos, input logic eos);
    req         = '0;
    req.valid   = 1'b1;
    req.rd_wr   = rd_wr;
    req.Node_id = node;
    req.PE_tag  = tag;
    req.data    = data;
    req.wr_sos  = sos;
    req.wr_eos  = eos;
    idle(1);
    req = '0;
  endtask

  task automatic do_write(input logic [NODE_ID_W-1:0] node, input int n, input bit use_rand);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = use_rand ? DATA_W'($urandom) : DATA_W'(32'h11 * (i + 1));
      if (i < int'(FV)) model[idx_of(node)][i] = d;
      else              exp_err = 1'b1;
      beat(1'b1, node, '0, d, i == 0, i == n - 1);
    end
  endtask

  task automatic push_read(input logic [NODE_ID_W-1:0] node, input logic [PE_TAG_W-1:0] tag,
                           input int nbeats);
    exp_t e;
    for (int b = 0; b < nbeats; b++) begin
      e.tag  = tag;
      e.node = node;
      e.data = model[idx_of(node)][b];
      e.sos  = (b == 0);
      e.eos  = (b == int'(FV) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_read(input logic [NODE_ID_W-1:0] node, input logic [PE_TAG_W-1:0] tag,
                         input int gap);
    push_read(node, tag, FV);
    beat(1'b0, node, tag, '0, 1'b0, 1'b0);
    idle(FV - 1 + gap);
  endtask

  task automatic do_reset();
    req     = '0;
    reset   = 1'b1;
    idle(1);
    reset   = 1'b0;
    exp_err = 1'b0;
    check("err_after_reset", 32'(err), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req   = '0;
    reset = 1'b1;
    idle(2);
    check("reset_valid", 32'(rd_out.valid), 32'd0);
    check("reset_arb_eos", 32'(arb_out.eos), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < int'(NODES); i++) do_write(node_of(i), FV, 1'b1);
    check("err_after_fill", 32'(err), 32'd0);

    // Directed vector on node 5 then tagged read.
    do_write(8'd5, 4, 1'b0);
    check("err_after_write5", 32'(err), 32'd0);
    do_read(8'd5, 4'd2, 0);

    // Write immediately followed by read of the same node, then back-to-back bursts.
    do_write(node_of(7), 4, 1'b1);
    do_read(node_of(7), 4'd3, 0);
    do_write(node_of(12), 1, 1'b1);
    do_read(node_of(12), 4'd9, 0);
    do_read(8'd5, 4'd4, 0);
    do_read(node_of(7), 4'd5, 0);
    do_read(8'd5, 4'd6, 2);

    repeat (60) begin
      if ($urandom_range(0, 2) == 0)
        do_write(node_of($urandom_range(0, NODES - 1)), $urandom_range(1, FV), 1'b1);
      else
        do_read(node_of($urandom_range(0, NODES - 1)), PE_TAG_W'($urandom), $urandom_range(0, 2));
    end
    check("err_clean_random", 32'(err), 32'd0);

    // Wrong-bank write aliasing node 5's slot must be ignored.
    do_reset();
    do_write(8'd5, 4, 1'b1);
    for (int i = 0; i < 4; i++) beat(1'b1, 8'd4, '0, 16'hbeef, i == 0, i == 3);
    exp_err = 1'b1;
    check("err_wrong_bank_wr", 32'(err), 32'(exp_err));
    do_read(8'd5, 4'd1, 0);

    // Wrong-bank read produces nothing.
    do_reset();
    do_write(8'd5, 4, 1'b1);
    beat(1'b0, 8'd6, 4'd7, '0, 1'b0, 1'b0);
    exp_err = 1'b1;
    idle(FV);
    check("err_wrong_bank_rd", 32'(err), 32'(exp_err));
    do_read(8'd5, 4'd8, 0);

    // Write beat in IDLE without start-of-burst.
    do_reset();
    do_write(8'd5, 4, 1'b1);
    beat(1'b1, 8'd5, '0, 16'hdead, 1'b0, 1'b0);
    exp_err = 1'b1;
    check("err_no_sos", 32'(err), 32'(exp_err));
    do_read(8'd5, 4'd3, 0);

    // Read request during an active burst.
    do_reset();
    do_write(8'd5, 4, 1'b1);
    do_write(node_of(2), 4, 1'b1);
    push_read(8'd5, 4'd2, FV);
    beat(1'b0, 8'd5, 4'd2, '0, 1'b0, 1'b0);
    beat(1'b0, node_of(2), 4'd11, '0, 1'b0, 1'b0);
    exp_err = 1'b1;
    idle(FV - 2);
    check("err_rd_during_rd", 32'(err), 32'(exp_err));

    // Five-beat write: the fifth beat must not spill into the next node.
    do_reset();
    do_write(node_of(2), 4, 1'b1);
    do_write(8'd5, 5, 1'b0);
    check("err_5beat", 32'(err), 32'(exp_err));
    do_read(8'd5, 4'd2, 0);
    do_read(node_of(2), 4'd2, 0);

    // Start-of-burst inside a write burst restarts at beat 0.
    do_reset();
    beat(1'b1, 8'd5, '0, 16'h0a0a, 1'b1, 1'b0);
    beat(1'b1, 8'd5, '0, 16'h0b0b, 1'b0, 1'b0);
    beat(1'b1, 8'd5, '0, 16'h0c0c, 1'b1, 1'b0);
    beat(1'b1, 8'd5, '0, 16'h0d0d, 1'b0, 1'b0);
    beat(1'b1, 8'd5, '0, 16'h0e0e, 1'b0, 1'b0);
    beat(1'b1, 8'd5, '0, 16'h0f0f, 1'b0, 1'b1);
    model[1][0] = 16'h0c0c;
    model[1][1] = 16'h0d0d;
    model[1][2] = 16'h0e0e;
    model[1][3] = 16'h0f0f;
    exp_err = 1'b1;
    check("err_sos_restart", 32'(err), 32'(exp_err));
    do_read(8'd5, 4'd12, 0);

    // Reset two cycles into a read burst aborts it.
    do_reset();
    do_write(8'd5, 4, 1'b1);
    push_read(8'd5, 4'd2, 2);
    beat(1'b0, 8'd5, 4'd2, '0, 1'b0, 1'b0);
    idle(1);
    reset = 1'b1;
    idle(1);
    check("abort_valid", 32'(rd_out.valid), 32'd0);
    check("abort_arb_eos", 32'(arb_out.eos), 32'd0);
    reset   = 1'b0;
    exp_err = 1'b0;
    idle(1);
    check("abort_valid_after", 32'(rd_out.valid), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    idle(FV);
    check("abort_queue", 32'(exp_q.size()), 32'd0);

    // Bank is usable again right away.
    do_write(node_of(30), 4, 1'b1);
    do_read(node_of(30), 4'd15, 0);
    check("err_final", 32'(err), 32'd0);

    idle(4);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
